lut_cfg_loader: RTL and testbench
=================================

# lut_cfg_loader

Serial configuration loader that drives the block-style configuration port (`cclk`, `cen`, `config_in`) of a split two-stage LUT (`lut_sXX`-style, 2*MEM_SIZE config bits). It accepts a framed, parity-protected serial bitstream over a valid/ready handshake, assembles it in a private shift register, and commits it to a stable shadow register with a single-cycle `cen` strobe only if the frame parity checks. The block sits between the fabric configuration chain and each cluster's LUTs, and is the write end of the LUT configuration interface.

## Interface
- INPUTS, 4, LUT address width per stage.
- MEM_SIZE, 2**INPUTS, bits per LUT stage.
- CFG_W, 2*MEM_SIZE, configuration word width (derived; not overridden).
- cclk  input  1  configuration clock; all state is on the rising edge.
- crst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle frame start request; honoured only in IDLE.
- sin_valid  input  1  serial bit valid.
- sin_data  input  1  serial bit.
- sin_ready  output  1  loader accepts a bit this cycle.
- cen  output  1  one-cycle configuration enable to the LUT.
- config_out  output  CFG_W  configuration word to LUT `config_in`.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse on a successful commit.
- err  output  1  sticky parity error; cleared by next accepted start.

## Operation
- Reset values: FSM=IDLE; shift register, bit counter and config_out = 0; sin_ready, cen, busy, done, err = 0.
- A bit is accepted on a cycle with sin_valid && sin_ready; no other cycle changes the shift register or counter.
- FSM states:
  - IDLE: sin_ready=0. On start: clear the counter, the shift register, the parity accumulator and err; go to SHIFT.
  - SHIFT: sin_ready=1. Each accepted bit enters the shift register at the LSB (shreg <= {shreg[CFG_W-2:0], sin_data}), XORs into the parity accumulator and increments the counter. The first bit received ends at config_out[CFG_W-1], so the first MEM_SIZE bits configure the first LUT stage. When the CFG_W-th bit is accepted (counter == CFG_W-1 at acceptance), go to PARITY.
  - PARITY: sin_ready=1. The accepted bit is the even-parity bit. If the XOR of the accumulator and that bit is 0, go to COMMIT; otherwise set err and return to IDLE without touching config_out or cen.
  - COMMIT: sin_ready=0. config_out <= shreg; cen=1 and done=1 for this one cycle; return to IDLE.
- The counter is $clog2(CFG_W+1) bits wide and never wraps within a frame.
- A start pulse outside IDLE is ignored. A gap in sin_valid stalls the FSM indefinitely with no timeout.
- config_out changes only on the COMMIT edge and holds its value across failed frames.
- crst_n assertion mid-frame returns the block to reset values immediately, including config_out = 0; partial frames are discarded.

## Timing
- start in IDLE at cycle t: busy=1 and sin_ready=1 from t+1.
- With sin_valid held high, the frame occupies CFG_W+1 consecutive accepting cycles starting at t+1.
- After the parity bit is accepted at cycle p: cen=1, done=1 and the new config_out are visible during cycle p+1. They are sampled by the LUT on the edge ending p+1, so config_out is already stable when cen is high.
- busy falls at p+2. The earliest next start is honoured at p+2.
- Failed parity at cycle p: err=1 and busy=0 from p+1; cen stays 0.
- cen is a registered output and is never high for more than one consecutive cycle.
- Minimum frame-to-frame spacing: CFG_W+3 cycles.

## Test plan
- Reset, then a frame with INPUTS=4 (CFG_W=32): start, bits of 32'hDEADBEEF MSB-first, then parity bit 0 (popcount 24 is even) -> exactly one cen/done pulse, config_out=32'hDEADBEEF, err=0.
- Same frame with parity bit 1 -> err=1, cen never asserted, config_out still holds the previous value; the next start clears err.
- Frame of 32'h0000FFFF with random sin_valid gaps (about 50% duty) -> identical commit; the counter advances only on handshake cycles.
- start pulsed mid-SHIFT after 10 bits -> ignored; the frame completes normally with the original bits.
- crst_n pulsed low after 20 bits of a frame -> all outputs 0 within the same cycle. A fresh full frame of 32'h12345678 (popcount 13, parity bit 1) then commits correctly.
- Back-to-back frames 32'hAAAAAAAA then 32'h55555555 (parity bit 0 each), with start at the earliest legal cycle -> two cen pulses CFG_W+3 cycles apart and config_out updating to each value in turn.

Source files
------------

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for a split two-stage LUT.
// Receives a framed, even-parity-protected bitstream over valid/ready,
// assembles it in a private shift register and commits it to the LUT
// config port with a one-cycle cen strobe only when the parity checks.
module lut_cfg_loader #(
  parameter  int unsigned INPUTS   = 4,
  parameter  int unsigned MEM_SIZE = 2 ** INPUTS,
  localparam int unsigned CFG_W    = 2 * MEM_SIZE
) (
  input  logic             cclk,
  input  logic             crst_n,
  input  logic             start,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic             cen,
  output logic [CFG_W-1:0] config_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(CFG_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic               err_q, err_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               cen_q, cen_d;
  logic               done_q, done_d;
  logic               accept;

  // A bit moves only on a completed handshake.
  assign accept = sin_valid & ready_q;

  // State and datapath registers; reset clears everything including config_out.
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      cfg_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      cen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      err_q   <= err_d;
      cfg_q   <= cfg_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cen_q   <= cen_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they are
  // registered and line up with the state they describe.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    err_d   = err_q;
    cfg_d   = cfg_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          shreg_d = '0;
          par_d   = 1'b0;
          err_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_d = {shreg_q[CFG_W-2:0], sin_data};
          par_d   = par_q ^ sin_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CFG_W - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (accept) begin
          if ((par_q ^ sin_data) == 1'b0) begin
            // Load the word now so it is stable for the whole cen cycle.
            cfg_d   = shreg_q;
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == SHIFT) || (state_d == PARITY);
    busy_d  = (state_d != IDLE);
    cen_d   = (state_d == COMMIT);
    done_d  = (state_d == COMMIT);
  end

  assign sin_ready  = ready_q;
  assign busy       = busy_q;
  assign cen        = cen_q;
  assign done       = done_q;
  assign err        = err_q;
  assign config_out = cfg_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader (INPUTS=4, 32-bit config word).
module tb_lut_cfg_loader;

  localparam int unsigned CFG_W = 32;

  logic             cclk;
  logic             crst_n;
  logic             start;
  logic             sin_valid;
  logic             sin_data;
  logic             sin_ready;
  logic             cen;
  logic [CFG_W-1:0] config_out;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cen_n = 0;
  int cen_last = 0;
  int cen_prev = 0;
  logic cen_d1 = 1'b0;

  lut_cfg_loader #(.INPUTS(4)) dut (
    .cclk       (cclk),
    .crst_n     (crst_n),
    .start      (start),
    .sin_valid  (sin_valid),
    .sin_data   (sin_data),
    .sin_ready  (sin_ready),
    .cen        (cen),
    .config_out (config_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor on the inactive edge: counts cen pulses, records their
  // cycle and flags any cen that lasts two cycles.
  initial begin
    forever begin
      @(negedge cclk);
      cyc++;
      if (crst_n === 1'b1) begin
        chk("cen_single", 32'(cen & cen_d1), 32'd0);
        chk("cen_eq_done", 32'(cen), 32'(done));
      end
      if (cen === 1'b1) begin
        cen_n++;
        cen_prev = cen_last;
        cen_last = cyc;
      end
      cen_d1 = cen;
    end
  end

  // Drive one bit, optionally preceded by an idle gap carrying junk data.
  task automatic send_bit(input logic b, input bit gaps);
    int g;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      sin_valid = 1'b0;
      sin_data  = ~b;
      @(posedge cclk); #1;
    end
    sin_data  = b;
    sin_valid = 1'b1;
    g = 0;
    while (sin_ready !== 1'b1 && g < 20) begin
      @(posedge cclk); #1;
      g++;
    end
    if (g >= 20) chk("ready_timeout", 32'(sin_ready), 32'd1);
    @(posedge cclk); #1;
    sin_valid = 1'b0;
  endtask

  // Start a frame, send the word MSB first plus the parity bit; returns in
  // the cycle right after the parity bit was accepted.
  task automatic send_frame(input logic [31:0] w, input logic par, input bit gaps,
                            input int glitch_at);
    start = 1'b1;
    @(posedge cclk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(sin_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (i == glitch_at) start = 1'b1;
      send_bit(w[31-i], gaps);
      start = 1'b0;
    end
    send_bit(par, gaps);
  endtask

  initial begin
    int n0;
    crst_n    = 1'b0;
    start     = 1'b0;
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    repeat (3) @(posedge cclk);
    #1;
    chk("rst_cen", 32'(cen), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(sin_ready), 32'd0);
    chk("rst_cfg", config_out, 32'h0);
    crst_n = 1'b1;
    @(posedge cclk); #1;

    // Good frame.
    send_frame(32'hDEADBEEF, 1'b0, 1'b0, -1);
    chk("f1_cen", 32'(cen), 32'd1);
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_cfg", config_out, 32'hDEADBEEF);
    chk("f1_err", 32'(err), 32'd0);
    chk("f1_busy_commit", 32'(busy), 32'd1);
    @(posedge cclk); #1;
    chk("f1_busy_end", 32'(busy), 32'd0);
    chk("f1_cen_end", 32'(cen), 32'd0);
    chk("f1_pulses", 32'(cen_n), 32'd1);

    // Bad parity: err set, no commit, config_out kept.
    n0 = cen_n;
    send_frame(32'hDEADBEEF, 1'b1, 1'b0, -1);
    chk("f2_err", 32'(err), 32'd1);
    chk("f2_busy", 32'(busy), 32'd0);
    chk("f2_cen", 32'(cen), 32'd0);
    chk("f2_cfg", config_out, 32'hDEADBEEF);
    @(posedge cclk); #1;
    chk("f2_no_pulse", 32'(cen_n), 32'(n0));

    // Frame with valid gaps; its start also clears the sticky err.
    send_frame(32'h0000FFFF, 1'b0, 1'b1, -1);
    chk("f3_cen", 32'(cen), 32'd1);
    chk("f3_cfg", config_out, 32'h0000FFFF);
    chk("f3_err_cleared", 32'(err), 32'd0);
    @(posedge cclk); #1;

    // start during SHIFT after 10 bits is ignored.
    send_frame(32'hCAFE0123, 1'b1, 1'b0, 10);
    chk("f4_cen", 32'(cen), 32'd1);
    chk("f4_cfg", config_out, 32'hCAFE0123);
    @(posedge cclk); #1;

    // Reset in the middle of a frame.
    start = 1'b1;
    @(posedge cclk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(i[0], 1'b0);
    crst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ready", 32'(sin_ready), 32'd0);
    chk("mrst_cen", 32'(cen), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_cfg", config_out, 32'h0);
    @(posedge cclk); #1;
    crst_n = 1'b1;
    @(posedge cclk); #1;
    send_frame(32'h12345678, 1'b1, 1'b0, -1);
    chk("f5_cen", 32'(cen), 32'd1);
    chk("f5_cfg", config_out, 32'h12345678);
    @(posedge cclk); #1;

    // Back-to-back frames at the earliest legal start.
    send_frame(32'hAAAAAAAA, 1'b0, 1'b0, -1);
    chk("f6_cfg", config_out, 32'hAAAAAAAA);
    chk("f6_cen", 32'(cen), 32'd1);
    @(posedge cclk); #1;
    send_frame(32'h55555555, 1'b0, 1'b0, -1);
    chk("f7_cfg", config_out, 32'h55555555);
    chk("f7_cen", 32'(cen), 32'd1);
    @(posedge cclk); #1;
    chk("b2b_spacing", 32'(cen_last - cen_prev), 32'(CFG_W + 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
